// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit scheduler.
// Holds the FSM state encoding and the default requester and gap constants.
package uart_pkg;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_GAP_CYCLES = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_GAP
  } state_t;

  // Index of the requester 'off' places after 'base' on the ring.
  function automatic int wrap_idx(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at i_ptr and a one-hot
// grant is produced only while i_advance is high.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int N     = DEF_NUM_REQ,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  input  logic             i_advance,
  output logic [N-1:0]     o_grant
);

  logic             w_found;
  logic [PTR_W-1:0] w_idx;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the loop can leave it holding an old value (a latch).
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = PTR_W'(wrap_idx(int'(i_ptr), k, N));
      if (i_advance && !w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Packet-locked round-robin scheduler that feeds bytes from several requesters
// into a single UART transmitter, with a fixed idle gap after each byte.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_byte,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic [7:0]           uart_tx_byte,
  output logic                 uart_tx_start,
  input  logic                 uart_tx_done
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(GAP_CYCLES);

  state_t             r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [PTR_W-1:0]   r_owner;
  logic [PTR_W-1:0]   r_ptr;
  logic [7:0]         r_tx_byte;
  logic               r_tx_start;
  logic               r_last;
  logic [GAP_W-1:0]   r_gap_cnt;

  logic [NUM_REQ-1:0] w_arb_grant;
  logic [PTR_W-1:0]   w_arb_idx;
  logic [PTR_W-1:0]   w_ptr_next;
  logic [7:0]         w_owner_byte;
  logic               w_owner_last;
  logic               w_xfer;
  logic               w_byte_done;

  rr_arbiter #(.N(NUM_REQ), .PTR_W(PTR_W)) u_arb (
    .i_req     (req_valid),
    .i_ptr     (r_ptr),
    .i_advance (r_state == ST_IDLE),
    .o_grant   (w_arb_grant)
  );

  always_comb begin
    w_arb_idx    = '0;
    w_owner_byte = '0;
    w_owner_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_arb_grant[i]) w_arb_idx = PTR_W'(i);
      if (r_owner == PTR_W'(i)) begin
        w_owner_byte = req_byte[8*i +: 8];
        w_owner_last = req_last[i];
      end
    end
  end

  assign w_ptr_next  = (r_owner == PTR_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
  assign w_xfer      = (r_state == ST_LOAD) && |(req_valid & r_grant);
  // A byte is finished either at the end of its gap or, with no gap, on done.
  assign w_byte_done = ((r_state == ST_WAIT) && uart_tx_done && (GAP_CYCLES == 0)) ||
                       ((r_state == ST_GAP) && (r_gap_cnt == GAP_LAST));

  assign req_ready     = (r_state == ST_LOAD) ? r_grant : '0;
  assign grant         = r_grant;
  assign busy          = (r_state != ST_IDLE);
  assign uart_tx_byte  = r_tx_byte;
  assign uart_tx_start = r_tx_start;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_owner    <= '0;
      r_ptr      <= '0;
      r_tx_byte  <= 8'h00;
      r_tx_start <= 1'b0;
      r_last     <= 1'b0;
      r_gap_cnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_arb_grant) begin
            r_grant <= w_arb_grant;
            r_owner <= w_arb_idx;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (w_xfer) begin
            r_tx_byte  <= w_owner_byte;
            r_last     <= w_owner_last;
            r_tx_start <= 1'b1;
            r_state    <= ST_START;
          end
        end
        ST_START: begin
          r_tx_start <= 1'b0;
          r_state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (uart_tx_done && (GAP_CYCLES != 0)) begin
            r_gap_cnt <= '0;
            r_state   <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (r_gap_cnt != GAP_MAX) r_gap_cnt <= r_gap_cnt + 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_byte_done) begin
        if (r_last) begin
          r_grant <= '0;
          r_ptr   <= w_ptr_next;
          r_state <= ST_IDLE;
        end else begin
          r_state <= ST_LOAD;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: requester FIFOs, a fixed-latency UART
// model and a start monitor feed hand-computed checks.
module tb_uart_tx_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_byte = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic [3:0]  grant;
  logic        busy;
  logic [7:0]  uart_tx_byte;
  logic        uart_tx_start;
  logic        uart_tx_done;

  logic        auto_done = 1'b0;
  logic        man_done = 1'b0;
  int          tx_cnt = 0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          onehot_err = 0;
  int          idle_cyc = 0;

  logic [8:0]  src_mem [4][8];
  int          src_rd [4];
  int          src_wr [4];
  logic [3:0]  src_hold = '0;
  logic [3:0]  prev_pend = '0;

  logic [7:0]  start_byte [$];
  int          start_cyc [$];

  assign uart_tx_done = auto_done | man_done;

  uart_tx_sched #(.NUM_REQ(4), .GAP_CYCLES(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_byte      (req_byte),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .grant         (grant),
    .busy          (busy),
    .uart_tx_byte  (uart_tx_byte),
    .uart_tx_start (uart_tx_start),
    .uart_tx_done  (uart_tx_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // UART model: done pulses on the 4th negedge after start is seen.
  always @(negedge clk) begin
    auto_done = 1'b0;
    if (!rst_n) tx_cnt = 0;
    else begin
      if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) auto_done = 1'b1;
      end
      if (uart_tx_start) tx_cnt = 4;
    end
  end

  // Requester FIFOs: pop what transferred at the last edge, present the head.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst_n && prev_pend[i] && src_rd[i] < src_wr[i]) src_rd[i]++;
      if (rst_n && src_rd[i] < src_wr[i] && !src_hold[i]) begin
        req_valid[i]      = 1'b1;
        req_byte[8*i +: 8] = src_mem[i][src_rd[i][2:0]][7:0];
        req_last[i]       = src_mem[i][src_rd[i][2:0]][8];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
    end
    prev_pend = rst_n ? (req_valid & req_ready) : 4'b0000;
  end

  always @(negedge clk) begin
    if (uart_tx_start) begin
      start_byte.push_back(uart_tx_byte);
      start_cyc.push_back(cyc);
    end
    if ($countones(grant) > 1) onehot_err++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic push(input int id, input logic [7:0] b, input logic l);
    src_mem[id][src_wr[id][2:0]] = {l, b};
    src_wr[id]++;
  endtask

  task automatic flush();
    for (int i = 0; i < 4; i++) begin
      src_rd[i] = 0;
      src_wr[i] = 0;
    end
    src_hold = '0;
  endtask

  task automatic clear_log();
    start_byte.delete();
    start_cyc.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    flush();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_starts(input int n, input int budget, input string tag);
    int k = 0;
    while (start_byte.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_start_timeout"}, 32'(start_byte.size() >= n), 1);
  endtask

  task automatic wait_idle(input int n, input int budget, input string tag);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(start_byte.size() >= n && !busy) && k < budget);
    idle_cyc = cyc;
    check({tag, "_idle_timeout"}, 32'(start_byte.size() >= n && !busy), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    flush();
    // Reset values while rst_n is held low from time 0.
    #12;
    check("rst_grant", grant, 0);
    check("rst_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_start", uart_tx_start, 0);
    check("rst_byte", uart_tx_byte, 8'h00);
    #1 rst_n = 1'b1;

    // Single byte from requester 2, with latency and gap length.
    do_reset();
    clear_log();
    @(posedge clk); #1;
    push(2, 8'h41, 1'b1);
    @(negedge clk);
    check("t1_idle_busy", busy, 0);
    @(negedge clk);
    check("t1_grant", grant, 4'b0100);
    check("t1_ready", req_ready, 4'b0100);
    check("t1_no_start", uart_tx_start, 0);
    @(negedge clk);
    check("t1_start", uart_tx_start, 1);
    check("t1_byte", uart_tx_byte, 8'h41);
    check("t1_ready_off", req_ready, 0);
    @(negedge clk);
    check("t1_start_one_cycle", uart_tx_start, 0);
    check("t1_byte_hold", uart_tx_byte, 8'h41);
    wait_idle(1, 200, "t1");
    check("t1_num_starts", start_byte.size(), 1);
    check("t1_done_to_idle", idle_cyc - start_cyc[0], 21);

    // Simultaneous single-byte packets from 0, 1 and 3 after reset.
    do_reset();
    clear_log();
    @(posedge clk); #1;
    push(0, 8'h10, 1'b1);
    push(1, 8'h11, 1'b1);
    push(3, 8'h13, 1'b1);
    wait_idle(3, 400, "t2");
    check("t2_first", start_byte[0], 8'h10);
    check("t2_second", start_byte[1], 8'h11);
    check("t2_third", start_byte[2], 8'h13);
    check("t2_onehot", onehot_err, 0);

    // Packet lock: 3-byte packet from 1 while 0 becomes valid.
    clear_log();
    @(posedge clk); #1;
    push(1, 8'h61, 1'b0);
    push(1, 8'h62, 1'b0);
    push(1, 8'h63, 1'b1);
    wait_starts(1, 50, "t3");
    @(posedge clk); #1;
    push(0, 8'h50, 1'b1);
    wait_idle(4, 500, "t3");
    check("t3_b0", start_byte[0], 8'h61);
    check("t3_b1", start_byte[1], 8'h62);
    check("t3_b2", start_byte[2], 8'h63);
    check("t3_b3", start_byte[3], 8'h50);
    check("t3_gap01", start_cyc[1] - start_cyc[0], 22);
    check("t3_gap12", start_cyc[2] - start_cyc[1], 22);
    check("t3_gap23", start_cyc[3] - start_cyc[2], 23);

    // Stalled owner: 2 withholds its second byte, 0 must stay blocked.
    clear_log();
    @(posedge clk); #1;
    push(2, 8'h71, 1'b0);
    push(2, 8'h72, 1'b1);
    wait_starts(1, 50, "t4");
    @(posedge clk); #1;
    src_hold[2] = 1'b1;
    push(0, 8'h30, 1'b1);
    repeat (40) @(negedge clk);
    check("t4_stall_starts", start_byte.size(), 1);
    check("t4_stall_grant", grant, 4'b0100);
    check("t4_stall_ready", req_ready, 4'b0100);
    check("t4_stall_busy", busy, 1);
    check("t4_stall_byte", uart_tx_byte, 8'h71);
    @(posedge clk); #1;
    src_hold[2] = 1'b0;
    wait_idle(3, 400, "t4");
    check("t4_b0", start_byte[0], 8'h71);
    check("t4_b1", start_byte[1], 8'h72);
    check("t4_b2", start_byte[2], 8'h30);

    // Spurious done in IDLE and in GAP.
    clear_log();
    @(posedge clk); #1 man_done = 1'b1;
    @(posedge clk); #1 man_done = 1'b0;
    @(negedge clk);
    check("t5_idle_busy", busy, 0);
    check("t5_idle_grant", grant, 0);
    check("t5_idle_start", uart_tx_start, 0);
    @(posedge clk); #1;
    push(1, 8'h5A, 1'b1);
    wait_starts(1, 50, "t5");
    repeat (9) @(posedge clk);
    #1 man_done = 1'b1;
    @(posedge clk); #1 man_done = 1'b0;
    wait_idle(1, 200, "t5");
    check("t5_num_starts", start_byte.size(), 1);
    check("t5_gap_len", idle_cyc - start_cyc[0], 21);

    // Reset in WAIT mid-packet; pointer returns to requester 0.
    clear_log();
    @(posedge clk); #1;
    push(2, 8'h81, 1'b0);
    push(2, 8'h82, 1'b1);
    wait_starts(1, 50, "t6");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_grant", grant, 0);
    check("t6_rst_ready", req_ready, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_start", uart_tx_start, 0);
    check("t6_rst_byte", uart_tx_byte, 8'h00);
    flush();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_log();
    @(posedge clk); #1;
    push(1, 8'hB1, 1'b1);
    push(3, 8'h93, 1'b1);
    wait_idle(2, 300, "t6");
    check("t6_num_starts", start_byte.size(), 2);
    check("t6_first", start_byte[0], 8'hB1);
    check("t6_second", start_byte[1], 8'h93);

    check("onehot_total", onehot_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
